// File: rtl/mul_cell_combine.sv
// Two-stage combiner that folds the 16x16 partial products into the low 32 bits
// of a 32x32 product, with valid/ready back-pressure, flush and tag tracking.
module mul_cell_combine #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_p1,
    input  logic [31:0]      in_p2,
    input  logic [31:0]      in_p3,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    logic             vld_p1;
    logic             vld_p2;
    logic [15:0]      mid_p1;
    logic [31:0]      lo_p1;
    logic [TAG_W-1:0] tag_p1;
    logic [31:0]      res_p2;
    logic [TAG_W-1:0] tag_p2;
    logic             s1_adv;
    logic             s2_adv;
    logic             accept;
    logic             unused_hi;

    // Only the low halves of the cross products reach bits below 32.
    function automatic logic [15:0] mid_sum(input logic [15:0] a, input logic [15:0] b);
        return a + b;
    endfunction

    function automatic logic [31:0] combine(input logic [31:0] p1, input logic [15:0] mid);
        return p1 + {mid, 16'h0000};
    endfunction

    assign unused_hi = ^{in_p2[31:16], in_p3[31:16]};

    assign s2_adv   = !vld_p2 || out_ready;
    assign s1_adv   = !vld_p1 || s2_adv;
    assign in_ready = !reset && !flush && s1_adv;
    assign accept   = in_valid && in_ready;

    assign out_valid  = vld_p2;
    assign out_result = res_p2;
    assign out_tag    = tag_p2;
    assign busy       = vld_p1 || vld_p2;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (s2_adv) vld_p2 <= vld_p1;
            if (s1_adv) vld_p1 <= accept;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mid_p1 <= '0;
            lo_p1  <= '0;
            tag_p1 <= '0;
            res_p2 <= '0;
            tag_p2 <= '0;
        end else begin
            // S1: fold the two cross products
            if (accept) begin
                mid_p1 <= mid_sum(in_p2[15:0], in_p3[15:0]);
                lo_p1  <= in_p1;
                tag_p1 <= in_tag;
            end
            // S2: final 32-bit add, held while the consumer stalls
            if (s2_adv) begin
                res_p2 <= combine(lo_p1, mid_p1);
                tag_p2 <= tag_p1;
            end
        end
    end

endmodule

// File: tb/tb_mul_cell_combine.sv
// Scoreboard bench for mul_cell_combine: directed cases plus random operands
// checked against full 32x32 multiplication.
module tb_mul_cell_combine;

    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_p1 = '0;
    logic [31:0]      in_p2 = '0;
    logic [31:0]      in_p3 = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    typedef struct {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
        int               acc;
    } ent_t;

    ent_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic prev_rst = 1'b0;
    logic rnd_mode = 1'b0;
    logic stall = 1'b0;
    int   stall_lo = 1000000;
    int   stall_hi = 0;

    mul_cell_combine #(.TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_p1(in_p1), .in_p2(in_p2), .in_p3(in_p3), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: occupancy-based expectations, then pop on completed transfers.
    always @(negedge clk) begin
        logic exp_rdy;
        logic exp_vld;
        exp_rdy = !reset && !flush && (q.size() < 2 || out_ready);
        exp_vld = (q.size() != 0) && (cyc >= q[0].acc + 2);
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("busy", 32'(busy), 32'(q.size() != 0));
        chk("out_valid", 32'(out_valid), 32'(exp_vld));
        if (out_valid && exp_vld) begin
            chk("out_result", out_result, q[0].res);
            chk("out_tag", 32'(out_tag), 32'(q[0].tag));
        end
        if (prev_rst) begin
            chk("reset_result", out_result, 32'h0);
            chk("reset_tag", 32'(out_tag), 32'h0);
        end
        prev_rst = reset;
        if (reset || flush) q.delete();
        else if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_mode) out_ready = 1'($urandom_range(0, 1));
        else          out_ready = !(stall || (cyc >= stall_lo && cyc <= stall_hi));
    endtask

    task automatic send(input logic [31:0] p1, input logic [31:0] p2, input logic [31:0] p3,
                        input logic [TAG_W-1:0] tag, input logic [31:0] exp);
        ent_t e;
        int   n;
        logic done;
        in_valid = 1'b1;
        in_p1 = p1;
        in_p2 = p2;
        in_p3 = p3;
        in_tag = tag;
        n = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            #2;
            if (in_ready) begin
                e.res = exp;
                e.tag = tag;
                e.acc = cyc;
                q.push_back(e);
                done = 1'b1;
            end else if (n > 64) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got in_ready=0 expected 1 within 64 cycles");
                done = 1'b1;
            end
            n++;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic send_src(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag);
        logic [63:0] full;
        full = {32'h0, a} * {32'h0, b};
        send(32'(a[15:0]) * 32'(b[15:0]), 32'(a[15:0]) * 32'(b[31:16]),
             32'(a[31:16]) * 32'(b[15:0]), tag, full[31:0]);
    endtask

    initial begin
        int start;
        int n;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // directed values
        send(32'h8, 32'h6, 32'h4, 5'd3, 32'h000A0008);
        send(32'hFFFE0001, 32'hFFFE0001, 32'h0, 5'd4, 32'hFFFF0001);
        send(32'h0, 32'h00008000, 32'h00008000, 5'd5, 32'h0);
        send_src(32'h00010002, 32'h00030004, 5'd9);
        send_src(32'hFFFFFFFF, 32'hFFFFFFFF, 5'd10);
        repeat (4) tick();

        // back-pressure: tags 1..6 with out_ready low for cycles 3..6
        start = cyc;
        stall_lo = start + 3;
        stall_hi = start + 6;
        for (int i = 1; i <= 6; i++) send_src($urandom, $urandom, 5'(i));
        repeat (6) tick();
        stall_lo = 1000000;

        // full throughput
        for (int i = 0; i < 16; i++) send_src($urandom, $urandom, 5'(i));
        repeat (4) tick();

        // flush with two entries in flight and a simultaneous input
        stall = 1'b1;
        tick();
        send_src($urandom, $urandom, 5'd1);
        send_src($urandom, $urandom, 5'd2);
        flush = 1'b1;
        in_valid = 1'b1;
        in_tag = 5'd7;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        stall = 1'b0;
        tick();
        send_src($urandom, $urandom, 5'd8);
        repeat (4) tick();

        // reset with both stages valid
        stall = 1'b1;
        tick();
        send_src($urandom, $urandom, 5'd11);
        send_src($urandom, $urandom, 5'd12);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        stall = 1'b0;
        tick();
        send_src($urandom, $urandom, 5'd13);
        repeat (4) tick();

        // random traffic with random back-pressure
        rnd_mode = 1'b1;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) tick();
            send_src($urandom, $urandom, 5'($urandom_range(0, 31)));
        end
        rnd_mode = 1'b0;
        tick();
        n = 0;
        while (q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d entries outstanding expected 0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
